maze_mem_responder: RTL and testbench

- Maze-map responder for the intelligent rat. Holds the 16x16 cell bitmap, where 1 means wall or visited and 0 means free.
- Serves the rat's RD/WR/Din/X/Y requests and returns Dout.
- A host-side loader FSM fills the map row by row before a run and can bulk-clear it.
- Keeps a running count of set cells for the test harness and status.

---
 rtl/maze_pkg.sv | 17 +
 rtl/row_popcount.sv | 19 +
 rtl/maze_mem_responder.sv | 129 ++++++++++++
 tb/tb_maze_mem_responder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared constants, FSM state type and cell encoding for the maze-map responder.
package maze_pkg;

    localparam int unsigned DIM = 16;
    localparam int unsigned AW  = 4;
    localparam int unsigned CW  = 9;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CLEAR
    } maze_mem_state_t;

    localparam logic CELL_FREE    = 1'b0;
    localparam logic CELL_BLOCKED = 1'b1;

endpackage

// File: rtl/row_popcount.sv
// Combinational population count of one map row.
module row_popcount
    import maze_pkg::*;
#(
    parameter int unsigned W  = DIM,
    parameter int unsigned OW = AW + 1
) (
    input  logic [W-1:0]  i_row,
    output logic [OW-1:0] o_count
);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < int'(W); i++) begin
            o_count = o_count + OW'(i_row[i]);
        end
    end

endmodule

// File: rtl/maze_mem_responder.sv
// 16x16 maze bitmap serving rat reads/writes, with a host row loader, bulk clear
// and a running count of set cells.
module maze_mem_responder
    import maze_pkg::*;
(
    input  logic            CLK,
    input  logic            RST,
    input  logic            RD,
    input  logic            WR,
    input  logic            Din,
    input  logic [AW-1:0]   X,
    input  logic [AW-1:0]   Y,
    output logic            Dout,
    input  logic            Ld_Start,
    input  logic            Ld_Valid,
    input  logic [DIM-1:0]  Ld_Row,
    output logic            Ld_Ready,
    input  logic            Clr_Start,
    output logic            Busy,
    output logic            Loaded,
    output logic            Drop,
    output logic [CW-1:0]   Count
);

    maze_mem_state_t r_state;
    logic [DIM-1:0]  r_map [DIM];
    logic [AW-1:0]   r_row;
    logic            r_dout;
    logic            r_ld_ready;
    logic            r_busy;
    logic            r_loaded;
    logic            r_drop;
    logic [CW-1:0]   r_count;

    logic [AW:0]     w_pop;
    logic            w_old;
    logic            w_last_row;

    row_popcount #(
        .W  (DIM),
        .OW (AW + 1)
    ) u_row_popcount (
        .i_row   (Ld_Row),
        .o_count (w_pop)
    );

    assign w_old      = r_map[Y][X];
    assign w_last_row = (r_row == AW'(DIM - 1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < int'(DIM); i++) begin
                r_map[i] <= {DIM{CELL_FREE}};
            end
            r_state    <= IDLE;
            r_row      <= '0;
            r_dout     <= 1'b0;
            r_ld_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_loaded   <= 1'b0;
            r_drop     <= 1'b0;
            r_count    <= '0;
        end else begin
            r_drop <= r_busy && (RD || WR);
            unique case (r_state)
                IDLE: begin
                    // Read samples the pre-write cell, giving read-before-write.
                    if (RD) begin
                        r_dout <= w_old;
                    end
                    if (WR) begin
                        r_map[Y][X] <= Din;
                        if (Din == CELL_BLOCKED && w_old == CELL_FREE) begin
                            r_count <= r_count + CW'(1);
                        end else if (Din == CELL_FREE && w_old == CELL_BLOCKED) begin
                            r_count <= r_count - CW'(1);
                        end
                    end
                    if (Clr_Start) begin
                        r_state  <= CLEAR;
                        r_row    <= '0;
                        r_loaded <= 1'b0;
                        r_busy   <= 1'b1;
                        r_count  <= '0;
                    end else if (Ld_Start) begin
                        r_state    <= LOAD;
                        r_row      <= '0;
                        r_loaded   <= 1'b0;
                        r_busy     <= 1'b1;
                        r_ld_ready <= 1'b1;
                        r_count    <= '0;
                    end
                end
                LOAD: begin
                    if (Ld_Valid) begin
                        r_map[r_row] <= Ld_Row;
                        r_count      <= r_count + CW'(w_pop);
                        r_row        <= r_row + 1'b1;
                        if (w_last_row) begin
                            r_state    <= IDLE;
                            r_busy     <= 1'b0;
                            r_ld_ready <= 1'b0;
                            r_loaded   <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    r_map[r_row] <= {DIM{CELL_FREE}};
                    r_row        <= r_row + 1'b1;
                    if (w_last_row) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign Dout     = r_dout;
    assign Ld_Ready = r_ld_ready;
    assign Busy     = r_busy;
    assign Loaded   = r_loaded;
    assign Drop     = r_drop;
    assign Count    = r_count;

endmodule

// File: tb/tb_maze_mem_responder.sv
// Directed self-checking bench for maze_mem_responder.
module tb_maze_mem_responder;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        RD = 1'b0, WR = 1'b0, Din = 1'b0;
    logic [3:0]  X = '0, Y = '0;
    logic        Dout;
    logic        Ld_Start = 1'b0, Ld_Valid = 1'b0;
    logic [15:0] Ld_Row = '0;
    logic        Ld_Ready;
    logic        Clr_Start = 1'b0;
    logic        Busy, Loaded, Drop;
    logic [8:0]  Count;

    int checks = 0;
    int errors = 0;

    maze_mem_responder dut (
        .CLK       (CLK),
        .RST       (RST),
        .RD        (RD),
        .WR        (WR),
        .Din       (Din),
        .X         (X),
        .Y         (Y),
        .Dout      (Dout),
        .Ld_Start  (Ld_Start),
        .Ld_Valid  (Ld_Valid),
        .Ld_Row    (Ld_Row),
        .Ld_Ready  (Ld_Ready),
        .Clr_Start (Clr_Start),
        .Busy      (Busy),
        .Loaded    (Loaded),
        .Drop      (Drop),
        .Count     (Count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic rd(input logic [3:0] x, input logic [3:0] y);
        RD = 1'b1; X = x; Y = y;
        tick();
        RD = 1'b0;
    endtask

    task automatic wr(input logic [3:0] x, input logic [3:0] y, input logic d);
        WR = 1'b1; Din = d; X = x; Y = y;
        tick();
        WR = 1'b0; Din = 1'b0;
    endtask

    // Pulses Ld_Start then offers rows until n_acc rows are accepted.
    task automatic do_load(input logic [15:0] r0, input logic [15:0] rn, input bit gapped,
                           input bit poke, input int n_acc, output int drops,
                           output bit busy_ok);
        int  acc;
        int  c;
        bit  valid;
        Ld_Start = 1'b1;
        tick();
        Ld_Start = 1'b0;
        acc = 0; c = 0; drops = 0; busy_ok = 1'b1;
        while (acc < n_acc && c < 200) begin
            valid    = !(gapped && (c % 3 == 2));
            Ld_Valid = valid;
            Ld_Row   = (acc == 0) ? r0 : rn;
            if (poke && !valid) begin
                RD = 1'b1; WR = 1'b1; Din = 1'b1; X = 4'd1; Y = 4'd1;
            end
            if (!Busy || !Ld_Ready) busy_ok = 1'b0;
            tick();
            if (Drop) drops++;
            RD = 1'b0; WR = 1'b0; Din = 1'b0;
            if (valid) acc++;
            c++;
        end
        Ld_Valid = 1'b0;
        check("load_accepts", acc, n_acc);
    endtask

    int drops;
    bit busy_ok;
    int n;
    int ones;

    initial begin
        #2 RST = 1'b0;
        #1;
        check("rst_dout", Dout, 0);
        check("rst_busy", Busy, 0);
        check("rst_ready", Ld_Ready, 0);
        check("rst_loaded", Loaded, 0);
        check("rst_drop", Drop, 0);
        check("rst_count", Count, 0);
        tick();
        @(negedge CLK);
        RST = 1'b1;
        tick();

        rd(4'd3, 4'd5);
        check("rd_3_5", Dout, 0);
        check("idle_count", Count, 0);
        check("idle_busy", Busy, 0);

        // Gapped load; the gap cycles carry rat accesses that must be dropped.
        do_load(16'hFFFF, 16'h0001, 1'b1, 1'b1, 16, drops, busy_ok);
        check("load1_busy", busy_ok, 1);
        check("load1_drops", drops, 7);
        check("load1_busy_fall", Busy, 0);
        check("load1_loaded", Loaded, 1);
        check("load1_count", Count, 31);
        check("load1_dout_held", Dout, 0);
        rd(4'd0, 4'd0);
        check("rd_0_0", Dout, 1);
        rd(4'd1, 4'd1);
        check("rd_1_1", Dout, 0);
        check("drop_idle", Drop, 0);

        RD = 1'b1; WR = 1'b1; Din = 1'b1; X = 4'd7; Y = 4'd2;
        tick();
        RD = 1'b0; WR = 1'b0; Din = 1'b0;
        check("rbw_dout", Dout, 0);
        check("rbw_count", Count, 32);
        rd(4'd7, 4'd2);
        check("rd_7_2", Dout, 1);
        wr(4'd7, 4'd2, 1'b0);
        check("wr0_count", Count, 31);
        wr(4'd0, 4'd0, 1'b1);
        check("wr_same_count", Count, 31);

        do_load(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16, drops, busy_ok);
        check("full_count", Count, 256);
        check("full_loaded", Loaded, 1);

        Clr_Start = 1'b1;
        tick();
        Clr_Start = 1'b0;
        check("clr_count", Count, 0);
        check("clr_loaded", Loaded, 0);
        check("clr_ready", Ld_Ready, 0);
        n = 0;
        while (Busy && n < 100) begin
            tick();
            n++;
        end
        check("clr_busy_cycles", n, 16);
        ones = 0;
        for (int y = 0; y < 16; y++) begin
            for (int x = 0; x < 16; x++) begin
                rd(4'(x), 4'(y));
                if (Dout !== 1'b0) ones++;
            end
        end
        check("clr_reads", ones, 0);

        Ld_Start = 1'b1; Clr_Start = 1'b1;
        tick();
        Ld_Start = 1'b0; Clr_Start = 1'b0;
        check("both_busy", Busy, 1);
        check("both_clear_wins", Ld_Ready, 0);
        n = 0;
        while (Busy && n < 100) begin
            tick();
            n++;
        end
        check("both_cycles", n, 16);

        wr(4'd0, 4'd0, 1'b1);
        rd(4'd0, 4'd0);
        check("pre_rst_dout", Dout, 1);
        do_load(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 8, drops, busy_ok);
        check("mid_count", Count, 128);
        check("mid_busy", Busy, 1);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check("mid_rst_dout", Dout, 0);
        check("mid_rst_busy", Busy, 0);
        check("mid_rst_ready", Ld_Ready, 0);
        check("mid_rst_count", Count, 0);
        check("mid_rst_loaded", Loaded, 0);
        @(negedge CLK);
        RST = 1'b1;
        tick();
        rd(4'd0, 4'd0);
        check("post_rst_rd", Dout, 0);

        do_load(16'h8000, 16'h0000, 1'b0, 1'b0, 16, drops, busy_ok);
        check("restart_count", Count, 1);
        check("restart_loaded", Loaded, 1);
        rd(4'd15, 4'd0);
        check("restart_row0", Dout, 1);
        rd(4'd15, 4'd8);
        check("restart_row8", Dout, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
